scc_memory_responder: RTL and testbench
=======================================

# scc_memory_responder

Synthesizable instruction/data memory responder for the SCC core: the target end of the CPU's instruction-fetch and data load/store ports. Holds one byte-addressable, little-endian instruction array and one data array, and answers word-wide fetch, load and store requests with registered, single-cycle read latency. Sits beside `CPU` in the SoC top level and replaces the behavioural memory models in simulation flows.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address bits decoded; each array is 2**ADDR_W bytes.
- `INST_INIT`, "": hex image loaded into instruction array at time zero; skipped if empty.
- `DATA_INIT`, "": hex image loaded into data array at time zero; skipped if empty.
- `NOP_WORD`, 32'hC8000000: value driven on `instruction_memory_v` during/after reset.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `instruction_memory_en` in 1: fetch request.
- `instruction_memory_a` in 32: fetch byte address.
- `instruction_memory_v` out 32: fetched word.
- `data_memory_a` in 32: load/store byte address.
- `data_memory_read` in 1: load request.
- `data_memory_write` in 1: store request.
- `data_memory_out_v` in 32: store data (CPU-out).
- `data_memory_in_v` out 32: load data (CPU-in).
- `data_valid` out 1: pulses high the cycle after an accepted load.
- `fault` out 1: sticky access-error flag.

## Operation
- Byte order: word at address A = {mem[A+3], mem[A+2], mem[A+1], mem[A]}; A+k computed modulo 2**ADDR_W (wraps at top of array).
- Address bits above ADDR_W-1 are ignored for indexing; nonzero upper bits set `fault` (range error). Access still performed on the wrapped low address.
- Fetch: when `instruction_memory_en` high at edge, `instruction_memory_v` loads the word; otherwise holds.
- Load: when `data_memory_read` high at edge, `data_memory_in_v` loads the word and `data_valid` is 1 next cycle; otherwise `data_memory_in_v` holds and `data_valid` is 0.
- Store: when `data_memory_write` high at edge, four bytes of `data_memory_out_v` written at A..A+3.
- Read and write same edge, overlapping bytes: load returns pre-store contents (read-before-write).
- Instruction and data arrays are independent; stores never alter the instruction array.
- `fault` sticky once set; cleared only by `reset`.
- Reset (async assert): `instruction_memory_v`=NOP_WORD, `data_memory_in_v`=0, `data_valid`=0, `fault`=0. Array contents not cleared. Requests during reset ignored; a store in flight when reset asserts is dropped if reset precedes the edge.

## Timing
- Fetch/load latency: request sampled at edge N, data on outputs after edge N, stable through edge N+1.
- Back-to-back requests every cycle supported; no stalls, no ready signal.
- Store data visible to a load sampled at edge N+1 or later.
- `fault` rises after the edge that sampled the offending request.
- Reset deassertion: first request honoured at first rising edge after deassert.

## Configuration
- `SCC_MEM_ALIGN_CHECK_EN` defined: load or store with `data_memory_a[1:0]`≠0, or fetch with `instruction_memory_a[1:0]`≠0, sets `fault`; misaligned stores suppressed (array unchanged); misaligned loads/fetches still return the wrapped unaligned word.
- Undefined: unaligned accesses fully legal, performed as byte-wise little-endian with wrap, never fault on alignment.

## Test plan
- Reset: assert `reset` mid-run with `data_memory_in_v`=32'h12345678 -> immediately `instruction_memory_v`=32'hC8000000, `data_memory_in_v`=0, `data_valid`=0, `fault`=0.
- Store 32'hDEADBEEF at 0x0010, load 0x0010 next cycle -> 32'hDEADBEEF, `data_valid` one cycle; byte load at 0x0011 word -> 32'h??DEADBE with mem[0x14] in top byte.
- Same-edge read+write at 0x0020 (old 32'h0, new 32'hCAFEF00D) -> load returns 32'h0; following load returns 32'hCAFEF00D.
- Wrap: store 32'hAABBCCDD at 0xFFFE (ADDR_W=16) -> mem[0xFFFE]=DD, [0xFFFF]=CC, [0x0000]=BB, [0x0001]=AA; `fault`=0 unless align check enabled.
- Range: fetch at 0x0001_0004 -> word from 0x0004 returned, `fault`=1 and stays 1 until `reset`.
- With `SCC_MEM_ALIGN_CHECK_EN`: store 32'h11111111 at 0x0042 -> array unchanged, `fault`=1; without macro -> bytes 0x42..0x45 written, `fault`=0.

Source files
------------

// File: rtl/scc_memory_responder.sv
// Instruction/data memory responder for the SCC core: byte-addressed little-endian arrays,
// registered single-cycle fetch/load, word stores. Optional SCC_MEM_ALIGN_CHECK_EN adds alignment faults.
module scc_memory_responder #(
  parameter int unsigned ADDR_W    = 16,
  parameter string       INST_INIT = "",
  parameter string       DATA_INIT = "",
  parameter logic [31:0] NOP_WORD  = 32'hC8000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instruction_memory_en,
  input  logic [31:0] instruction_memory_a,
  output logic [31:0] instruction_memory_v,
  input  logic [31:0] data_memory_a,
  input  logic        data_memory_read,
  input  logic        data_memory_write,
  input  logic [31:0] data_memory_out_v,
  output logic [31:0] data_memory_in_v,
  output logic        data_valid,
  output logic        fault
);

  localparam int unsigned MemBytes = 2 ** ADDR_W;

  logic [7:0] r_imem [MemBytes];
  logic [7:0] r_dmem [MemBytes];

  logic [31:0] r_inst_v;
  logic [31:0] r_data_v;
  logic        r_data_valid;
  logic        r_fault;

  logic [ADDR_W-1:0] w_ia [4];
  logic [ADDR_W-1:0] w_da [4];
  logic [31:0]       w_i_word;
  logic [31:0]       w_d_word;
  logic              w_i_range;
  logic              w_d_range;
  logic              w_i_mis;
  logic              w_d_mis;
  logic              w_st_en;
  logic              w_fault_set;

  // Byte addresses wrap at the top of the array by virtue of the ADDR_W-bit sum.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_ia[k] = instruction_memory_a[ADDR_W-1:0] + ADDR_W'(k);
      w_da[k] = data_memory_a[ADDR_W-1:0] + ADDR_W'(k);
    end
  end

  assign w_i_word = {r_imem[w_ia[3]], r_imem[w_ia[2]], r_imem[w_ia[1]], r_imem[w_ia[0]]};
  assign w_d_word = {r_dmem[w_da[3]], r_dmem[w_da[2]], r_dmem[w_da[1]], r_dmem[w_da[0]]};

  assign w_i_range = |(instruction_memory_a >> ADDR_W);
  assign w_d_range = |(data_memory_a >> ADDR_W);

`ifdef SCC_MEM_ALIGN_CHECK_EN
  assign w_i_mis = |instruction_memory_a[1:0];
  assign w_d_mis = |data_memory_a[1:0];
`else
  assign w_i_mis = 1'b0;
  assign w_d_mis = 1'b0;
`endif

  // Misaligned stores are suppressed only when the alignment check is built in.
  assign w_st_en = data_memory_write & ~w_d_mis;

  assign w_fault_set = (instruction_memory_en & (w_i_range | w_i_mis))
                     | ((data_memory_read | data_memory_write) & (w_d_range | w_d_mis));

  // Array is not reset; a store coinciding with asserted reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && w_st_en) begin
      for (int k = 0; k < 4; k++) begin
        r_dmem[w_da[k]] <= data_memory_out_v[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst_v     <= NOP_WORD;
      r_data_v     <= 32'h0;
      r_data_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      if (instruction_memory_en) begin
        r_inst_v <= w_i_word;
      end
      // Nonblocking read alongside the store gives read-before-write on overlap.
      if (data_memory_read) begin
        r_data_v <= w_d_word;
      end
      r_data_valid <= data_memory_read;
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign instruction_memory_v = r_inst_v;
  assign data_memory_in_v     = r_data_v;
  assign data_valid           = r_data_valid;
  assign fault                = r_fault;

endmodule

// File: tb/tb_scc_memory_responder.sv
// Directed-vector bench for scc_memory_responder (default build, alignment check disabled).
module tb_scc_memory_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instruction_memory_en = 1'b0;
  logic [31:0] instruction_memory_a = 32'h0;
  logic [31:0] instruction_memory_v;
  logic [31:0] data_memory_a = 32'h0;
  logic        data_memory_read = 1'b0;
  logic        data_memory_write = 1'b0;
  logic [31:0] data_memory_out_v = 32'h0;
  logic [31:0] data_memory_in_v;
  logic        data_valid;
  logic        fault;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  scc_memory_responder #(
    .ADDR_W   (16),
    .NOP_WORD (32'hC8000000)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .instruction_memory_en (instruction_memory_en),
    .instruction_memory_a  (instruction_memory_a),
    .instruction_memory_v  (instruction_memory_v),
    .data_memory_a         (data_memory_a),
    .data_memory_read      (data_memory_read),
    .data_memory_write     (data_memory_write),
    .data_memory_out_v     (data_memory_out_v),
    .data_memory_in_v      (data_memory_in_v),
    .data_valid            (data_valid),
    .fault                 (fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    data_memory_a     = a;
    data_memory_out_v = d;
    data_memory_write = 1'b1;
    tick();
    data_memory_write = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    data_memory_a    = a;
    data_memory_read = 1'b1;
    tick();
    data_memory_read = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    instruction_memory_a  = a;
    instruction_memory_en = 1'b1;
    tick();
    instruction_memory_en = 1'b0;
  endtask

  initial begin
    // Instruction array has no write port; seed a few bytes as stimulus.
    dut.r_imem[4] = 8'h01;
    dut.r_imem[5] = 8'h02;
    dut.r_imem[6] = 8'h03;
    dut.r_imem[7] = 8'h04;
    dut.r_imem[8] = 8'h05;

    #1 reset = 1'b1;
    #1;
    check_eq("rst_inst_v", instruction_memory_v, 32'hC8000000);
    check_eq("rst_data_v", data_memory_in_v, 32'h0);
    check_eq("rst_valid", 32'(data_valid), 32'h0);
    check_eq("rst_fault", 32'(fault), 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Store then load, and an unaligned byte-wise load.
    store(32'h14, 32'h00000077);
    store(32'h10, 32'hDEADBEEF);
    load(32'h10);
    check_eq("ld_10", data_memory_in_v, 32'hDEADBEEF);
    check_eq("ld_10_valid", 32'(data_valid), 32'h1);
    tick();
    check_eq("valid_drop", 32'(data_valid), 32'h0);
    check_eq("ld_hold", data_memory_in_v, 32'hDEADBEEF);
    load(32'h11);
    check_eq("ld_11", data_memory_in_v, 32'h77DEADBE);

    // Read and write on the same edge.
    store(32'h20, 32'h0);
    data_memory_a     = 32'h20;
    data_memory_out_v = 32'hCAFEF00D;
    data_memory_read  = 1'b1;
    data_memory_write = 1'b1;
    tick();
    data_memory_read  = 1'b0;
    data_memory_write = 1'b0;
    check_eq("rbw_old", data_memory_in_v, 32'h0);
    load(32'h20);
    check_eq("rbw_new", data_memory_in_v, 32'hCAFEF00D);

    // Wrap at the top of the 64 KiB array.
    store(32'hFFFA, 32'h0);
    store(32'h0002, 32'h0);
    store(32'hFFFE, 32'hAABBCCDD);
    load(32'hFFFE);
    check_eq("wrap_ld", data_memory_in_v, 32'hAABBCCDD);
    load(32'hFFFC);
    check_eq("wrap_lo", data_memory_in_v, 32'hCCDD0000);
    load(32'h0000);
    check_eq("wrap_hi", data_memory_in_v, 32'h0000AABB);
    check_eq("wrap_fault", 32'(fault), 32'h0);

    // Unaligned store is legal without the alignment check.
    store(32'h3E, 32'h0);
    store(32'h42, 32'h11111111);
    load(32'h42);
    check_eq("unal_ld", data_memory_in_v, 32'h11111111);
    load(32'h40);
    check_eq("unal_ld40", data_memory_in_v, 32'h11110000);
    check_eq("unal_fault", 32'(fault), 32'h0);

    // Fetch path, hold, independence from data stores.
    check_eq("inst_nop_hold", instruction_memory_v, 32'hC8000000);
    fetch(32'h4);
    check_eq("fetch_4", instruction_memory_v, 32'h04030201);
    store(32'h4, 32'hFFFFFFFF);
    check_eq("fetch_hold", instruction_memory_v, 32'h04030201);
    fetch(32'h5);
    check_eq("fetch_5", instruction_memory_v, 32'h05040302);
    fetch(32'h4);
    check_eq("imem_indep", instruction_memory_v, 32'h04030201);
    check_eq("fetch_fault", 32'(fault), 32'h0);

    // Out-of-range fetch: wrapped word returned, sticky fault.
    fetch(32'h0001_0004);
    check_eq("range_fetch", instruction_memory_v, 32'h04030201);
    check_eq("range_fault", 32'(fault), 32'h1);
    tick();
    load(32'h10);
    check_eq("fault_sticky", 32'(fault), 32'h1);

    // Asynchronous reset mid-cycle.
    store(32'h30, 32'h12345678);
    load(32'h30);
    check_eq("pre_rst_ld", data_memory_in_v, 32'h12345678);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_inst_v", instruction_memory_v, 32'hC8000000);
    check_eq("arst_data_v", data_memory_in_v, 32'h0);
    check_eq("arst_valid", 32'(data_valid), 32'h0);
    check_eq("arst_fault", 32'(fault), 32'h0);
    data_memory_a    = 32'h30;
    data_memory_read = 1'b1;
    tick();
    data_memory_read = 1'b0;
    check_eq("rst_ignore", data_memory_in_v, 32'h0);
    reset = 1'b0;
    load(32'h30);
    check_eq("post_rst_ld", data_memory_in_v, 32'h12345678);
    check_eq("post_rst_valid", 32'(data_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
